// File: rtl/intdiv_seq.sv
// rtl/intdiv_seq.sv - sequential radix-2 restoring divider for div/divu/rem/remu and W-forms
// Busy for N+1 cycles (N = 32 or XLEN); divide-by-zero and signed overflow finish in one.
module intdiv_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            IntDivE,
  input  logic [2:0]      Funct3E,
  input  logic            W64E,
  input  logic [XLEN-1:0] MDUForwardedSrcAE,
  input  logic [XLEN-1:0] MDUForwardedSrcBE,
  input  logic            FlushE,
  input  logic            StallM,
  output logic            DivBusyE,
  output logic            DivValidE,
  output logic [XLEN-1:0] DivResultE
);
  localparam int CW = $clog2(XLEN + 1);
  localparam int SH = XLEN - 32;
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = ~(XLEN'(32'h7FFF_FFFF));
  localparam logic [CW-1:0] N_X = CW'(XLEN);
  localparam logic [CW-1:0] N_W = CW'(32);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] div_abs;
  logic            is_w, sel_rem, neg_q, neg_r;

  logic            start, w_eff, s_op, a_neg, b_neg, b_zero, ovf;
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs;
  logic [XLEN:0]   shifted, r_next;
  logic [XLEN+1:0] trial;
  logic [XLEN-1:0] q_next, q_fin, r_fin, res_fin;
  logic            unused_funct3;

  // Extend the low 32 bits of v to XLEN, signed or unsigned.
  function automatic logic [XLEN-1:0] ext32(input logic sgn, input logic [XLEN-1:0] v);
    logic signed [XLEN-1:0] t;
    logic [XLEN-1:0] r;
    t = $signed(v << SH);
    if (sgn) r = t >>> SH;
    else     r = (v << SH) >> SH;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] wfix(input logic w, input logic [XLEN-1:0] v);
    return w ? ext32(1'b1, v) : v;
  endfunction

  assign unused_funct3 = Funct3E[2];

  always_comb begin
    start  = (state == IDLE) && IntDivE && !FlushE;
    w_eff  = W64E && (XLEN == 64);
    s_op   = !Funct3E[0];
    a_ext  = w_eff ? ext32(s_op, MDUForwardedSrcAE) : MDUForwardedSrcAE;
    b_ext  = w_eff ? ext32(s_op, MDUForwardedSrcBE) : MDUForwardedSrcBE;
    a_neg  = s_op && a_ext[XLEN-1];
    b_neg  = s_op && b_ext[XLEN-1];
    a_abs  = a_neg ? -a_ext : a_ext;
    b_abs  = b_neg ? -b_ext : b_ext;
    b_zero = (b_ext == '0);
    ovf    = s_op && (a_ext == (w_eff ? MIN_W : MIN_X)) && (&b_ext);
  end

  // One restoring step; the final result is formed from the step's output.
  always_comb begin
    shifted = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    trial   = {rem_q[XLEN], shifted} - {2'b00, div_abs};
    if (trial[XLEN+1]) begin
      r_next = shifted;
      q_next = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      r_next = trial[XLEN:0];
      q_next = {quo_q[XLEN-2:0], 1'b1};
    end
    q_fin   = neg_q ? -q_next : q_next;
    r_fin   = neg_r ? -r_next[XLEN-1:0] : r_next[XLEN-1:0];
    res_fin = wfix(is_w, sel_rem ? r_fin : q_fin);
  end

  assign DivBusyE = !reset && (start || (state == BUSY));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      div_abs    <= '0;
      is_w       <= 1'b0;
      sel_rem    <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      DivValidE  <= 1'b0;
      DivResultE <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          is_w    <= w_eff;
          sel_rem <= Funct3E[1];
          neg_q   <= a_neg ^ b_neg;
          neg_r   <= a_neg;
          div_abs <= b_abs;
          rem_q   <= '0;
          // W-form dividends sit in the top half so 32 steps consume them.
          quo_q   <= w_eff ? (a_abs << SH) : a_abs;
          if (b_zero) begin
            DivResultE <= wfix(w_eff, Funct3E[1] ? a_ext : '1);
            DivValidE  <= 1'b1;
            state      <= DONE;
          end else if (ovf) begin
            DivResultE <= Funct3E[1] ? '0 : a_ext;
            DivValidE  <= 1'b1;
            state      <= DONE;
          end else begin
            count <= w_eff ? N_W : N_X;
            state <= BUSY;
          end
        end
        BUSY: if (FlushE) begin
          count <= '0;
          state <= IDLE;
        end else begin
          rem_q <= r_next;
          quo_q <= q_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            DivResultE <= res_fin;
            DivValidE  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: if (FlushE || !StallM) begin
          DivValidE <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          DivValidE <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_intdiv_seq.sv
// tb/tb_intdiv_seq.sv - randomized self-checking bench for intdiv_seq against a behavioural model
module tb_intdiv_seq;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            IntDivE;
  logic [2:0]      Funct3E;
  logic            W64E;
  logic [XLEN-1:0] MDUForwardedSrcAE;
  logic [XLEN-1:0] MDUForwardedSrcBE;
  logic            FlushE;
  logic            StallM;
  logic            DivBusyE;
  logic            DivValidE;
  logic [XLEN-1:0] DivResultE;

  always #5 clk = ~clk;

  intdiv_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .IntDivE(IntDivE), .Funct3E(Funct3E), .W64E(W64E),
    .MDUForwardedSrcAE(MDUForwardedSrcAE), .MDUForwardedSrcBE(MDUForwardedSrcBE),
    .FlushE(FlushE), .StallM(StallM), .DivBusyE(DivBusyE), .DivValidE(DivValidE),
    .DivResultE(DivResultE)
  );

  int          n_tests = 0;
  int          n_fail = 0;
  logic        chk_en = 1'b0;
  logic        exp_busy = 1'b0;
  logic        exp_valid = 1'b0;
  logic [63:0] exp_res = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Architectural result and latency (cycles from start to first valid cycle).
  function automatic logic [63:0] model(input logic [2:0] f3, input logic w,
                                        input logic [63:0] a, input logic [63:0] b,
                                        output int lat);
    logic sgn, rem;
    logic signed [31:0] sa32, sb32;
    logic [31:0] res32;
    logic signed [63:0] sa, sb;
    logic [63:0] res;
    sgn = !f3[0];
    rem = f3[1];
    if (w) begin
      sa32 = a[31:0];
      sb32 = b[31:0];
      if (b[31:0] == 32'd0) begin
        res32 = rem ? a[31:0] : 32'hFFFF_FFFF;
        lat = 1;
      end else if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
        res32 = rem ? 32'd0 : a[31:0];
        lat = 1;
      end else begin
        lat = 33;
        if (sgn) res32 = rem ? sa32 % sb32 : sa32 / sb32;
        else     res32 = rem ? a[31:0] % b[31:0] : a[31:0] / b[31:0];
      end
      return {{32{res32[31]}}, res32};
    end
    sa = a;
    sb = b;
    if (b == 64'd0) begin
      res = rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
      lat = 1;
    end else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
      res = rem ? 64'd0 : a;
      lat = 1;
    end else begin
      lat = 65;
      if (sgn) res = rem ? sa % sb : sa / sb;
      else     res = rem ? a % b : a / b;
    end
    return res;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {63'd0, DivBusyE}, {63'd0, exp_busy});
      check("valid", {63'd0, DivValidE}, {63'd0, exp_valid});
      check("result", DivResultE, exp_res);
    end
  end

  // Called one step after a rising edge with the divider idle.
  task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input int stall);
    int lat;
    logic [63:0] res, prev;
    res  = model(f3, w, a, b, lat);
    prev = exp_res;
    Funct3E = f3; W64E = w; MDUForwardedSrcAE = a; MDUForwardedSrcBE = b; IntDivE = 1'b1;
    for (int k = 0; k <= lat + stall; k++) begin
      StallM    = (k >= lat) && (k < lat + stall);
      exp_busy  = (k < lat);
      exp_valid = (k >= lat);
      exp_res   = (k >= lat) ? res : prev;
      @(posedge clk); #1;
    end
    IntDivE = 1'b0; StallM = 1'b0; exp_busy = 1'b0; exp_valid = 1'b0;
  endtask

  task automatic flush_op(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                          input int at);
    Funct3E = f3; W64E = 1'b0; MDUForwardedSrcAE = a; MDUForwardedSrcBE = b; IntDivE = 1'b1;
    for (int k = 0; k <= at; k++) begin
      exp_busy = 1'b1; exp_valid = 1'b0;
      FlushE = (k == at);
      @(posedge clk); #1;
    end
    FlushE = 1'b0; IntDivE = 1'b0; exp_busy = 1'b0; exp_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_8000_0000;
      4: return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int lat;
    logic [63:0] m;
    reset = 1'b1; IntDivE = 1'b0; Funct3E = 3'b100; W64E = 1'b0;
    MDUForwardedSrcAE = '0; MDUForwardedSrcBE = '0; FlushE = 1'b0; StallM = 1'b0;

    m = model(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, lat);
    check("pin_div_m7_2", m, 64'hFFFF_FFFF_FFFF_FFFD);
    check("pin_div_lat", 64'(lat), 64'd65);
    m = model(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, lat);
    check("pin_rem_m7_2", m, 64'hFFFF_FFFF_FFFF_FFFF);
    m = model(3'b101, 1'b0, 64'h1234, 64'd0, lat);
    check("pin_divu_by0", m, 64'hFFFF_FFFF_FFFF_FFFF);
    check("pin_by0_lat", 64'(lat), 64'd1);
    m = model(3'b111, 1'b0, 64'h1234, 64'd0, lat);
    check("pin_remu_by0", m, 64'h1234);
    m = model(3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat);
    check("pin_div_ovf", m, 64'h8000_0000_0000_0000);
    m = model(3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat);
    check("pin_rem_ovf", m, 64'd0);
    m = model(3'b101, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd1, lat);
    check("pin_divuw", m, 64'hFFFF_FFFF_8000_0000);
    check("pin_divuw_lat", 64'(lat), 64'd33);
    m = model(3'b101, 1'b0, 64'd100, 64'd7, lat);
    check("pin_divu_100_7", m, 64'd14);

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, DivBusyE}, 64'd0);
    check("rst_valid", {63'd0, DivValidE}, 64'd0);
    check("rst_result", DivResultE, 64'd0);
    reset = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    run_op(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0);
    run_op(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0);
    run_op(3'b101, 1'b0, 64'h1234, 64'd0, 0);
    run_op(3'b111, 1'b0, 64'h1234, 64'd0, 0);
    run_op(3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op(3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op(3'b101, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd1, 0);
    run_op(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5);

    flush_op(3'b101, 64'd1000, 64'd3, 10);
    run_op(3'b101, 1'b0, 64'd100, 64'd7, 0);

    // Flush in the same cycle as a start must not start anything.
    Funct3E = 3'b101; MDUForwardedSrcAE = 64'd9; MDUForwardedSrcBE = 64'd2;
    IntDivE = 1'b1; FlushE = 1'b1; exp_busy = 1'b0; exp_valid = 1'b0;
    @(posedge clk); #1;
    IntDivE = 1'b0; FlushE = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    for (int i = 0; i < 60; i++)
      run_op(3'b100 | 3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), pick(), pick(),
             $urandom_range(0, 2));

    run_op(3'b101, 1'b0, 64'd100, 64'd7, 0);
    // Asynchronous reset in the middle of an iteration.
    Funct3E = 3'b100; W64E = 1'b0; MDUForwardedSrcAE = 64'd12345; MDUForwardedSrcBE = 64'd7;
    IntDivE = 1'b1; exp_busy = 1'b1; exp_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    chk_en = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("async_busy", {63'd0, DivBusyE}, 64'd0);
    check("async_valid", {63'd0, DivValidE}, 64'd0);
    check("async_result", DivResultE, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0; IntDivE = 1'b0; exp_busy = 1'b0; exp_valid = 1'b0; exp_res = '0;
    chk_en = 1'b1;
    @(posedge clk); #1;
    run_op(3'b110, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd3, 1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
